galcounter_ctrl: RTL and testbench

Command sequencer and round-robin arbiter that shares one GAL-style WIDTH-bit counter (Set-load, Clear, active-low count enable, priority Set > Clear > count) between NREQ requesters. Each requester issues one command (NOP, LOAD, CLEAR, COUNT n) with a Req/Done handshake. The block drives the counter's Set, Clear, OE and D pins and reads back its Q. It sits in the device wrapper between the requester logic and the counter instance.

---
 rtl/galcounter_ctrl_if.sv | 13 +
 rtl/galcounter_ctrl.sv | 124 ++++++++++++
 tb/tb_galcounter_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/galcounter_ctrl_if.sv
// galcounter_ctrl_if: requester-side Req/Cmd/Arg -> Grant/Done handshake bundle for galcounter_ctrl.
interface galcounter_ctrl_if #(
  parameter int NREQ = 2,
  parameter int WIDTH = 4
);
  logic [NREQ-1:0]       Req;
  logic [2*NREQ-1:0]     Cmd;
  logic [WIDTH*NREQ-1:0] Arg;
  logic [NREQ-1:0]       Grant;
  logic [NREQ-1:0]       Done;
  modport master (output Req, Cmd, Arg, input Grant, Done);
  modport slave (input Req, Cmd, Arg, output Grant, Done);
endinterface

// File: rtl/galcounter_ctrl.sv
// galcounter_ctrl: round-robin command sequencer sharing one GAL counter among NREQ requesters.
// Define GALCTRL_WRAP_STOP_EN to stop COUNT at all-ones and flag Ovf instead of wrapping.
module galcounter_ctrl #(
  parameter int NREQ = 2,
  parameter int WIDTH = 4
) (
  input  logic             Clock,
  input  logic             nReset,
  galcounter_ctrl_if.slave bus,
  output logic             Busy,
  output logic             Set,
  output logic             Clear,
  output logic             OE,
  output logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] Q,
  output logic             Ovf
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state;
  logic [NREQ-1:0] grant, done, onehot;
  logic [IW-1:0] last, pick, idx;
  logic found, oe_r, ovf;
  logic [1:0] cmd, pick_cmd;
  logic [WIDTH-1:0] rem, pick_arg;
  assign bus.Grant = grant;
  assign bus.Done = done;
  assign Ovf = ovf;
  assign onehot = NREQ'(1) << pick;
  assign pick_cmd = 2'(bus.Cmd >> (2 * pick));
  assign pick_arg = WIDTH'(bus.Arg >> (WIDTH * pick));
`ifdef GALCTRL_WRAP_STOP_EN
  assign OE = oe_r | (&Q);
`else
  logic unused_q;
  assign OE = oe_r;
  assign unused_q = ^Q;
`endif
  // first requester after the last winner, wrapping
  always_comb begin
    pick = last;
    found = 1'b0;
    idx = last;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(last) + k) % NREQ);
      if (!found && bus.Req[idx]) begin
        pick = idx;
        found = 1'b1;
      end
    end
  end
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state <= IDLE;
      grant <= '0;
      done <= '0;
      Busy <= 1'b0;
      Set <= 1'b0;
      Clear <= 1'b0;
      oe_r <= 1'b1;
      D <= '0;
      ovf <= 1'b0;
      last <= IW'(NREQ - 1);
      cmd <= 2'b00;
      rem <= '0;
    end else begin
      case (state)
        IDLE: if (found) begin
          last <= pick;
          grant <= onehot;
          Busy <= 1'b1;
          cmd <= pick_cmd;
          rem <= pick_arg;
          if (pick_cmd == 2'b01) begin
            Set <= 1'b1;
            D <= pick_arg;
            state <= EXEC;
          end else if (pick_cmd == 2'b10) begin
            Clear <= 1'b1;
            state <= EXEC;
          end else if (pick_cmd == 2'b11 && pick_arg != '0) begin
            oe_r <= 1'b0;
            state <= EXEC;
          end else begin
            done <= onehot;
            state <= DONE;
          end
        end
        EXEC: begin
          if (cmd != 2'b11) begin
            Set <= 1'b0;
            Clear <= 1'b0;
            done <= grant;
            state <= DONE;
          end
`ifdef GALCTRL_WRAP_STOP_EN
          else if (&Q) begin
            oe_r <= 1'b1;
            ovf <= 1'b1;
            done <= grant;
            state <= DONE;
          end
`endif
          else begin
            rem <= rem - WIDTH'(1);
            if (rem == WIDTH'(1)) begin
              oe_r <= 1'b1;
              done <= grant;
              state <= DONE;
            end
          end
        end
        DONE: begin
          grant <= '0;
          done <= '0;
          Busy <= 1'b0;
          ovf <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_galcounter_ctrl.sv
// tb_galcounter_ctrl: drives galcounter_ctrl against a GAL counter model and checks each
// operation against latency/value rules computed directly from the command semantics.
module tb_galcounter_ctrl;
  localparam int NREQ = 2, W = 4, MAXV = (1 << W) - 1, CW = 2 * NREQ, AW = W * NREQ;
  logic Clock = 1'b0, nReset = 1'b1;
  logic Busy, Set, Clear, OE, Ovf;
  logic [W-1:0] D;
  logic [W-1:0] Q = '0;
  int checks = 0, errors = 0;
  int mq = 0, mlast = NREQ - 1;
  int o_lat, o_q, o_set, o_clr, o_oel, o_done, o_ovf, o_gcyc, o_gbad;
  int e_lat, e_set, e_clr, e_oel, e_ovf;

  galcounter_ctrl_if #(.NREQ(NREQ), .WIDTH(W)) bus ();
  galcounter_ctrl #(.NREQ(NREQ), .WIDTH(W)) dut (
    .Clock(Clock), .nReset(nReset), .bus(bus), .Busy(Busy), .Set(Set), .Clear(Clear),
    .OE(OE), .D(D), .Q(Q), .Ovf(Ovf)
  );

  always #5 Clock = ~Clock;
  // GAL counter: Set > Clear > count (OE low); not reset by the controller
  always @(posedge Clock) Q <= Set ? D : Clear ? '0 : !OE ? Q + 1'b1 : Q;

  task automatic predict(input logic [1:0] c, input int a);
    int steps;
    e_set = 0; e_clr = 0; e_oel = 0; e_ovf = 0; e_lat = 1;
    if (c == 2'b01) begin e_lat = 2; e_set = 1; mq = a; end
    else if (c == 2'b10) begin e_lat = 2; e_clr = 1; mq = 0; end
    else if (c == 2'b11 && a > 0) begin
      steps = a;
`ifdef GALCTRL_WRAP_STOP_EN
      if (MAXV - mq < a) begin steps = MAXV - mq; e_ovf = 1; end
`endif
      e_lat = e_ovf ? steps + 2 : a + 1;
      e_oel = steps;
      mq = (mq + steps) % (MAXV + 1);
    end
  endtask

  task automatic run_op(input int r, input logic [1:0] c, input logic [W-1:0] a, input bit scramble);
    bus.Req = '0; bus.Req[r] = 1'b1; bus.Cmd[2*r +: 2] = c; bus.Arg[W*r +: W] = a;
    o_lat = -1; o_q = -1; o_set = 0; o_clr = 0; o_oel = 0; o_done = 0; o_ovf = 0; o_gcyc = 0; o_gbad = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge Clock); #1;
      if (scramble) begin bus.Cmd = CW'($urandom); bus.Arg = AW'($urandom); bus.Req[r] = 1'b0; end
      o_set += int'(Set); o_clr += int'(Clear); o_oel += int'(!OE);
      o_gcyc += int'(bus.Grant != 0); o_done += int'(bus.Done != 0); o_ovf += int'(Ovf && bus.Done[r]);
      if ((bus.Grant != 0 && bus.Grant != NREQ'(1 << r)) || (bus.Done != 0 && bus.Done != NREQ'(1 << r)) ||
          (Ovf && !bus.Done[r]) || (Busy != (bus.Grant != 0))) o_gbad++;
      if (o_lat >= 0) break;
      if (bus.Done[r]) begin o_lat = k; o_q = int'(Q); bus.Req = '0; end
    end
    bus.Req = '0;
    mlast = r;
  endtask

  task automatic test_reset();
    #2 nReset = 1'b0; #1;
    checks++; if ({bus.Grant, bus.Done} !== '0) begin errors++; $display("FAIL reset_grant_done got %b exp 0", {bus.Grant, bus.Done}); end
    checks++; if ({Busy, Set, Clear, OE, Ovf} !== 5'b00010) begin errors++; $display("FAIL reset_ctl got %b exp 00010", {Busy, Set, Clear, OE, Ovf}); end
    checks++; if (D !== '0) begin errors++; $display("FAIL reset_d got %0d exp 0", D); end
    repeat (2) @(posedge Clock); #1;
    nReset = 1'b1; mlast = NREQ - 1;
    @(posedge Clock); #1;
    checks++; if ({Busy, OE, Q} !== {2'b01, W'(0)}) begin errors++; $display("FAIL reset_idle got %b exp 010000", {Busy, OE, Q}); end
  endtask

  task automatic test_load();
    predict(2'b01, 5); run_op(0, 2'b01, 4'b0101, 1'b0);
    checks++; if (o_lat != e_lat) begin errors++; $display("FAIL load_lat got %0d exp %0d", o_lat, e_lat); end
    checks++; if (o_q != mq) begin errors++; $display("FAIL load_q got %0d exp %0d", o_q, mq); end
    checks++; if (o_set != 1) begin errors++; $display("FAIL load_set_cycles got %0d exp 1", o_set); end
    checks++; if (o_gcyc != 2 || o_done != 1 || o_gbad != 0) begin errors++; $display("FAIL load_handshake got g%0d d%0d bad%0d exp g2 d1 bad0", o_gcyc, o_done, o_gbad); end
  endtask

  task automatic test_count();
    predict(2'b11, 3); run_op(1, 2'b11, 4'd3, 1'b0);
    checks++; if (o_lat != 4) begin errors++; $display("FAIL count_lat got %0d exp 4", o_lat); end
    checks++; if (o_q != mq) begin errors++; $display("FAIL count_q got %0d exp %0d", o_q, mq); end
    checks++; if (o_oel != 3) begin errors++; $display("FAIL count_oe_low got %0d exp 3", o_oel); end
    checks++; if (o_done != 1 || o_gbad != 0) begin errors++; $display("FAIL count_handshake got d%0d bad%0d exp d1 bad0", o_done, o_gbad); end
  endtask

  task automatic test_arbitration();
    int order[$];
    int multi = 0, gap_bad = 0, w, lst;
    bit prev_done = 1'b0;
    logic [NREQ-1:0] prev_g = '0;
    nReset = 1'b0; #2 nReset = 1'b1;
    mlast = NREQ - 1;
    bus.Req = 2'b11; bus.Cmd = 4'b1111; bus.Arg = {4'd1, 4'd1};
    for (int k = 0; k < 30; k++) begin
      @(posedge Clock); #1;
      if ($countones(bus.Grant) > 1) multi++;
      if (prev_done && bus.Grant != 0) gap_bad++;
      if (prev_g == 0 && bus.Grant != 0) order.push_back($clog2(bus.Grant));
      prev_g = bus.Grant; prev_done = (bus.Done != 0);
      if (order.size() == 4 && prev_done) break;
    end
    bus.Req = '0;
    @(posedge Clock); #1;
    checks++; if (order.size() != 4) begin errors++; $display("FAIL arb_grants got %0d exp 4", order.size()); end
    lst = mlast;
    for (int i = 0; i < 4 && i < order.size(); i++) begin
      w = (lst + 1) % NREQ;
      checks++; if (order[i] != w) begin errors++; $display("FAIL arb_order[%0d] got %0d exp %0d", i, order[i], w); end
      lst = w;
      predict(2'b11, 1);
    end
    mlast = lst;
    checks++; if (multi != 0 || gap_bad != 0) begin errors++; $display("FAIL arb_onehot_gap got multi%0d gap%0d exp 0 0", multi, gap_bad); end
    checks++; if (int'(Q) != mq) begin errors++; $display("FAIL arb_q got %0d exp %0d", Q, mq); end
  endtask

  task automatic test_reset_mid();
    int seen = 0, w;
    bus.Req = '0; bus.Req[0] = 1'b1; bus.Cmd[1:0] = 2'b11; bus.Arg[W-1:0] = W'(5);
    repeat (2) begin @(posedge Clock); #1; end
    nReset = 1'b0; #1;
    checks++; if ({OE, Busy, bus.Grant, bus.Done} !== {2'b10, NREQ'(0), NREQ'(0)}) begin errors++; $display("FAIL rstmid_outputs got %b exp 10 then zeros", {OE, Busy, bus.Grant, bus.Done}); end
    bus.Req = '0; #2 nReset = 1'b1;
    mq = (mq + 1) % (MAXV + 1); mlast = NREQ - 1;
    repeat (6) begin @(posedge Clock); #1; seen += int'(bus.Done != 0); end
    checks++; if (seen != 0) begin errors++; $display("FAIL rstmid_no_done got %0d exp 0", seen); end
    checks++; if (int'(Q) != mq) begin errors++; $display("FAIL rstmid_q got %0d exp %0d", Q, mq); end
    bus.Req = '1; bus.Cmd = '0;
    @(posedge Clock); #1;
    w = (mlast + 1) % NREQ;
    checks++; if (bus.Grant !== NREQ'(1 << w)) begin errors++; $display("FAIL rstmid_priority got %b exp %b", bus.Grant, NREQ'(1 << w)); end
    bus.Req = '0; mlast = w;
    @(posedge Clock); #1;
  endtask

  task automatic test_wrap();
    predict(2'b01, 14); run_op(0, 2'b01, 4'b1110, 1'b0);
    checks++; if (o_q != 14) begin errors++; $display("FAIL wrap_preload got %0d exp 14", o_q); end
    predict(2'b11, 4); run_op(1, 2'b11, 4'd4, 1'b0);
    checks++; if (o_q != mq) begin errors++; $display("FAIL wrap_q got %0d exp %0d", o_q, mq); end
    checks++; if (o_lat != e_lat) begin errors++; $display("FAIL wrap_lat got %0d exp %0d", o_lat, e_lat); end
    checks++; if (o_ovf != e_ovf || o_gbad != 0) begin errors++; $display("FAIL wrap_ovf got %0d bad%0d exp %0d bad0", o_ovf, o_gbad, e_ovf); end
    checks++; if (o_oel != e_oel) begin errors++; $display("FAIL wrap_oe_low got %0d exp %0d", o_oel, e_oel); end
  endtask

  task automatic test_nop_clear();
    predict(2'b00, 0); run_op(0, 2'b00, 4'd9, 1'b0);
    checks++; if (o_lat != 1 || o_q != mq) begin errors++; $display("FAIL nop got lat%0d q%0d exp lat1 q%0d", o_lat, o_q, mq); end
    checks++; if (o_set + o_clr + o_oel != 0 || o_done != 1) begin errors++; $display("FAIL nop_pins got s%0d c%0d oe%0d d%0d exp 0 0 0 1", o_set, o_clr, o_oel, o_done); end
    predict(2'b11, 0); run_op(1, 2'b11, 4'd0, 1'b0);
    checks++; if (o_lat != 1 || o_q != mq) begin errors++; $display("FAIL count0 got lat%0d q%0d exp lat1 q%0d", o_lat, o_q, mq); end
    checks++; if (o_set + o_clr + o_oel != 0 || o_done != 1) begin errors++; $display("FAIL count0_pins got s%0d c%0d oe%0d d%0d exp 0 0 0 1", o_set, o_clr, o_oel, o_done); end
    predict(2'b01, 10); run_op(0, 2'b01, 4'b1010, 1'b0);
    predict(2'b10, 0); run_op(1, 2'b10, 4'd7, 1'b0);
    checks++; if (o_q != 0 || o_lat != 2 || o_clr != 1) begin errors++; $display("FAIL clear got q%0d lat%0d clr%0d exp q0 lat2 clr1", o_q, o_lat, o_clr); end
  endtask

  task automatic test_random();
    int r, a;
    logic [1:0] c;
    bit s;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, NREQ - 1); c = 2'($urandom_range(0, 3)); a = $urandom_range(0, MAXV); s = 1'($urandom_range(0, 1));
      predict(c, a); run_op(r, c, W'(a), s);
      checks++; if (o_lat != e_lat) begin errors++; $display("FAIL rnd%0d_lat cmd%0d arg%0d got %0d exp %0d", i, c, a, o_lat, e_lat); end
      checks++; if (o_q != mq) begin errors++; $display("FAIL rnd%0d_q got %0d exp %0d", i, o_q, mq); end
      checks++; if (o_set != e_set) begin errors++; $display("FAIL rnd%0d_set got %0d exp %0d", i, o_set, e_set); end
      checks++; if (o_clr != e_clr) begin errors++; $display("FAIL rnd%0d_clr got %0d exp %0d", i, o_clr, e_clr); end
      checks++; if (o_oel != e_oel) begin errors++; $display("FAIL rnd%0d_oe_low got %0d exp %0d", i, o_oel, e_oel); end
      checks++; if (o_done != 1) begin errors++; $display("FAIL rnd%0d_done got %0d exp 1", i, o_done); end
      checks++; if (o_ovf != e_ovf) begin errors++; $display("FAIL rnd%0d_ovf got %0d exp %0d", i, o_ovf, e_ovf); end
      checks++; if (o_gcyc != e_lat) begin errors++; $display("FAIL rnd%0d_grant_cycles got %0d exp %0d", i, o_gcyc, e_lat); end
      checks++; if (o_gbad != 0) begin errors++; $display("FAIL rnd%0d_protocol got %0d exp 0", i, o_gbad); end
    end
  endtask

  initial begin
    bus.Req = '0; bus.Cmd = '0; bus.Arg = '0;
    test_reset();
    test_load();
    test_count();
    test_arbitration();
    test_reset_mid();
    test_wrap();
    test_nop_clear();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
